// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register-id width and hazard controller states.
package cpu_types_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hzstate_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the IF/ID instruction reads the register an ID/EX load writes.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             load_use
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = idex_MemRead && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: per-cycle advance/hold/bubble decisions for PC and the four
// pipeline registers, sticky halt, and cycle/stall performance counters.
module pl_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_branch_taken,
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             memwb_halt,
  output logic             pc_WEN,
  output logic             ifid_WEN,
  output logic             idex_WEN,
  output logic             exmem_WEN,
  output logic             memwb_WEN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  hzstate_t state, state_nxt;
  logic     squash_pending, squash_nxt;
  logic     load_use;
  logic     dmem_req;

  hazard_detect u_hazard_detect (
    .idex_MemRead (idex_MemRead),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .load_use     (load_use)
  );

  assign dmem_req = exmem_dREN | exmem_dWEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= RUN;
      squash_pending <= 1'b0;
      cycle_count    <= '0;
      stall_count    <= '0;
    end else begin
      state          <= state_nxt;
      squash_pending <= squash_nxt;
      if (state != HALTED) begin
        cycle_count <= cycle_count + CNT_W'(1);
        if (!pc_WEN) stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pc_WEN      = 1'b1;
    ifid_WEN    = 1'b1;
    idex_WEN    = 1'b1;
    exmem_WEN   = 1'b1;
    memwb_WEN   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;
    state_nxt   = state;
    squash_nxt  = squash_pending;

    if (state == HALTED) begin
      {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN} = '0;
      halted = 1'b1;
    end else if (memwb_halt) begin
      {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN} = '0;
      state_nxt  = HALTED;
      squash_nxt = 1'b0;
    end else if (dmem_req && !dhit) begin
      {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN} = '0;
      state_nxt = DWAIT;
    end else begin
      state_nxt = RUN;
      if (exmem_branch_taken) begin
        // a fetch still in flight at redirect returns a wrong-path word later
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        squash_nxt  = !ihit;
      end else if (load_use) begin
        pc_WEN     = 1'b0;
        ifid_WEN   = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_WEN     = 1'b0;
        ifid_flush = 1'b1;
      end else if (squash_pending) begin
        ifid_flush = 1'b1;
        squash_nxt = 1'b0;
      end
    end

    // while reset is asserted the datapath sees plain run behaviour
    if (RST) begin
      pc_WEN      = 1'b1;
      ifid_WEN    = 1'b1;
      idex_WEN    = 1'b1;
      exmem_WEN   = 1'b1;
      memwb_WEN   = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Randomized scoreboard bench for pl_hazard_ctrl with a rule-level reference model.
module tb_pl_hazard_ctrl;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic       dren;
    logic       dwen;
    logic       br;
    logic       mr;
    logic [4:0] idrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       halt;
  } stim_t;

  // wen = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem}
  typedef struct packed {
    logic [4:0]       wen;
    logic [2:0]       fl;
    logic             hlt;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stl;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ihit = 1'b0, dhit = 1'b0, exmem_dREN = 1'b0, exmem_dWEN = 1'b0;
  logic             exmem_branch_taken = 1'b0, idex_MemRead = 1'b0, memwb_halt = 1'b0;
  logic [4:0]       idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
  logic             pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic             ifid_flush, idex_flush, exmem_flush, halted;
  logic [CNT_W-1:0] cycle_count, stall_count;

  pl_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .ihit               (ihit),
    .dhit               (dhit),
    .exmem_dREN         (exmem_dREN),
    .exmem_dWEN         (exmem_dWEN),
    .exmem_branch_taken (exmem_branch_taken),
    .idex_MemRead       (idex_MemRead),
    .idex_rt            (idex_rt),
    .ifid_rs            (ifid_rs),
    .ifid_rt            (ifid_rt),
    .memwb_halt         (memwb_halt),
    .pc_WEN             (pc_WEN),
    .ifid_WEN           (ifid_WEN),
    .idex_WEN           (idex_WEN),
    .exmem_WEN          (exmem_WEN),
    .memwb_WEN          (memwb_WEN),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .exmem_flush        (exmem_flush),
    .halted             (halted),
    .cycle_count        (cycle_count),
    .stall_count        (stall_count)
  );

  always #5 CLK = ~CLK;

  exp_t             sb[$];
  int               n_vec = 0;
  int               n_err = 0;

  // reference model state
  bit               m_halted = 0;
  bit               m_squash = 0;
  logic [CNT_W-1:0] m_cyc = '0;
  logic [CNT_W-1:0] m_stl = '0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   lu;
    @(posedge CLK);
    #1;
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; exmem_dREN = s.dren; exmem_dWEN = s.dwen;
    exmem_branch_taken = s.br; idex_MemRead = s.mr; idex_rt = s.idrt;
    ifid_rs = s.rs; ifid_rt = s.rt; memwb_halt = s.halt;

    lu = s.mr && s.idrt != 0 && (s.idrt == s.rs || s.idrt == s.rt);
    e.wen = 5'b11111; e.fl = 3'b000; e.hlt = 1'b0; e.cyc = m_cyc; e.stl = m_stl;
    if (s.rst) begin
      m_halted = 0; m_squash = 0; m_cyc = '0; m_stl = '0;
    end else begin
      if (m_halted) begin
        e.wen = 5'b00000; e.hlt = 1'b1;
      end else if (s.halt) begin
        e.wen = 5'b00000;
      end else if ((s.dren || s.dwen) && !s.dhit) begin
        e.wen = 5'b00000;
      end else if (s.br) begin
        e.fl = 3'b111;
        m_squash = !s.ihit;
      end else if (lu) begin
        e.wen[4] = 1'b0; e.wen[3] = 1'b0; e.fl[1] = 1'b1;
      end else if (!s.ihit) begin
        e.wen[4] = 1'b0; e.fl[2] = 1'b1;
      end else if (m_squash) begin
        e.fl[2] = 1'b1;
        m_squash = 0;
      end
      if (!m_halted) begin
        m_cyc = m_cyc + 1'b1;
        if (!e.wen[4]) m_stl = m_stl + 1'b1;
        if (s.halt) begin
          m_halted = 1;
          m_squash = 0;
        end
      end
    end
    sb.push_back(e);
  endtask

  // monitor: one expected entry per presented cycle, compared mid-cycle
  always @(negedge CLK) begin
    exp_t e, g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g.wen = {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN};
      g.fl  = {ifid_flush, idex_flush, exmem_flush};
      g.hlt = halted;
      g.cyc = cycle_count;
      g.stl = stall_count;
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL vec%0d: got wen=%b fl=%b halted=%b cyc=%0d stl=%0d, required wen=%b fl=%b halted=%b cyc=%0d stl=%0d",
                 n_vec, g.wen, g.fl, g.hlt, g.cyc, g.stl, e.wen, e.fl, e.hlt, e.cyc, e.stl);
      end
    end
  end

  initial begin
    stim_t s;

    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);
    s = idle(); apply(s);

    // reset in the middle of a data miss
    s = idle(); s.dren = 1'b1; apply(s); apply(s);
    s.rst = 1'b1; apply(s);
    s = idle(); apply(s); apply(s);

    // load-use on rs, then the same shape with r0 as the load target
    s = idle(); s.mr = 1'b1; s.idrt = 5'd5; s.rs = 5'd5; apply(s);
    s = idle(); apply(s);
    s = idle(); s.mr = 1'b1; s.idrt = 5'd0; s.rs = 5'd0; apply(s);
    s = idle(); s.mr = 1'b1; s.idrt = 5'd9; s.rt = 5'd9; s.rs = 5'd2; apply(s);

    // three-cycle data miss, then completion
    s = idle(); s.dren = 1'b1; repeat (3) apply(s);
    s.dhit = 1'b1; apply(s);
    s = idle(); apply(s);
    s = idle(); s.dwen = 1'b1; s.br = 1'b1; apply(s);
    s.dhit = 1'b1; apply(s);

    // taken branch while fetch pending, then the squashed word arrives
    s = idle(); s.br = 1'b1; s.ihit = 1'b0; apply(s);
    s = idle(); apply(s); apply(s);

    // branch beats load-use
    s = idle(); s.br = 1'b1; s.mr = 1'b1; s.idrt = 5'd3; s.rt = 5'd3; apply(s);

    // halt is sticky until reset
    s = idle(); s.halt = 1'b1; apply(s);
    for (int i = 0; i < 6; i++) begin
      s = idle(); s.ihit = i[0]; s.dhit = i[1]; s.dren = i[0]; s.br = i[2]; apply(s);
    end
    s = idle(); s.rst = 1'b1; apply(s);
    s = idle(); apply(s);

    // long fetch stall: both counters wrap
    s = idle(); s.rst = 1'b1; apply(s);
    s = idle(); s.ihit = 1'b0;
    repeat (300) apply(s);

    for (int i = 0; i < 1000; i++) begin
      s.rst  = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 19) == 0);
      s.ihit = ($urandom_range(0, 3) != 0);
      s.dhit = $urandom_range(0, 1);
      s.dren = ($urandom_range(0, 4) == 0);
      s.dwen = ($urandom_range(0, 6) == 0);
      s.br   = ($urandom_range(0, 5) == 0);
      s.mr   = ($urandom_range(0, 2) == 0);
      s.idrt = 5'($urandom_range(0, 3));
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.halt = ($urandom_range(0, 79) == 0);
      apply(s);
    end

    @(negedge CLK);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pl_hazard_ctrl.md
# pl_hazard_ctrl

Pipeline hazard controller that drives the write-enable and flush inputs of all four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC write enable. It sits beside the datapath, observes memory hits, load-use dependencies, taken branches resolved at EX/MEM and the halt reaching WB, and decides each cycle which stages advance, hold or bubble. It also keeps a sticky halted state and cycle and stall counters for performance reporting.

## Interface
Parameters:
- CNT_W, 32, width of cycle and stall counters

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- ihit  in  1  instruction memory returned a valid word this cycle
- dhit  in  1  data memory completed the EX/MEM request this cycle
- exmem_dREN  in  1  EX/MEM stage holds a load
- exmem_dWEN  in  1  EX/MEM stage holds a store
- exmem_branch_taken  in  1  branch or jump resolved taken in EX/MEM; PC mux selects target
- idex_MemRead  in  1  ID/EX stage holds a load
- idex_rt  in  5  destination register of the ID/EX load
- ifid_rs, ifid_rt  in  5 each  source registers of the IF/ID instruction
- memwb_halt  in  1  halt instruction sits in MEM/WB
- pc_WEN  out  1  PC update enable
- ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN  out  1 each  register write enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  bubble insertion (flush has priority inside the register)
- halted  out  1  processor halted, sticky
- cycle_count  out  CNT_W  cycles since reset, frozen when halted
- stall_count  out  CNT_W  cycles with pc_WEN=0 while not halted

## Operation
- FSM states: RUN, DWAIT, HALTED. Reset -> RUN.
- dmem_req = exmem_dREN | exmem_dWEN. Registered flag squash_pending (reset 0).
- Output decision, strict priority (first match wins; unlisted outputs take RUN defaults: all WEN=1, all flush=0):
  1. HALTED: all WEN=0, all flush=0, halted=1.
  2. memwb_halt (any state except HALTED): all WEN=0; next state HALTED.
  3. dmem_req & !dhit: pc/ifid/idex/exmem WEN=0, memwb_WEN=0; next state DWAIT. DWAIT -> RUN on the cycle dhit=1 (that cycle uses rules 4-6).
  4. exmem_branch_taken: pc_WEN=1, ifid_flush=idex_flush=exmem_flush=1. If ihit=0 this cycle, set squash_pending.
  5. Load-use (idex_MemRead & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt)): pc_WEN=0, ifid_WEN=0, idex_flush=1.
  6. !ihit: pc_WEN=0, ifid_flush=1.
  7. squash_pending & ihit: ifid_flush=1, pc_WEN=1; clear squash_pending.
- squash_pending is cleared by rule 7, by reset, or on entry to HALTED; it is held during rules 3 and 5.
- Counters: cycle_count increments each cycle state!=HALTED (including the cycle entering HALTED); stall_count increments when pc_WEN=0 and state!=HALTED. Both wrap modulo 2^CNT_W.

## Timing
- Outputs are Mealy: combinational from state, squash_pending and current inputs, valid the same cycle; registers update at the next rising CLK.
- Load-use produces exactly one bubble: after one stall the load leaves ID/EX, so the condition drops.
- Branch redirect costs three bubbles; PC loads the target on the rule-4 edge.
- Reset values: state RUN, squash_pending 0, halted 0, counters 0. With RST=1, outputs read RUN defaults; RST overrides every state, including HALTED and DWAIT, on the next edge.
- Simultaneous events: a dmem miss overrides a taken branch; the branch is re-evaluated when dhit arrives, because EX/MEM is held. A branch overrides load-use.

## Structure
- Shared package cpu_types_pkg: add hzstate_t enum {RUN, DWAIT, HALTED}; the regbits width constant is reused for 5-bit register ids.
- A single sub-module, hazard_detect, is combinational: it computes the load-use signal.
- Everything else, including the FSM, squash flag and counters, lives in pl_hazard_ctrl.

## Test plan
- Reset mid-DWAIT (dmem_req=1, dhit=0, then RST=1 for 1 cycle) -> next cycle state RUN, all WEN=1, counters 0.
- Load r5 in ID/EX, ifid_rs=5, ihit=1 -> one cycle with pc_WEN=0, ifid_WEN=0, idex_flush=1; stall_count +1. Same case with idex_rt=0 -> no stall.
- dREN=1, dhit=0 for 3 cycles, then dhit=1 -> all WEN=0 for 3 cycles; stall_count=3; 4th cycle RUN defaults.
- exmem_branch_taken=1 with ihit=0, then ihit=1 a cycle later -> flush of all three stages; on the ihit cycle ifid_flush=1 and pc_WEN=1; squash_pending is 0 afterward.
- Branch taken and load-use in the same cycle -> branch outputs win (pc_WEN=1, three flushes).
- memwb_halt=1 -> all WEN=0, halted=1 from the next cycle onward; cycle_count frozen; ihit and dhit toggling has no effect until RST.
